// File: rtl/alu_slice_exec.sv
// alu_slice_exec: multi-cycle execute unit that processes operands SLICE bits
// per cycle, LSB slice first, with a registered carry between slices.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload steady until that edge. The
// consumer may raise or lower ready at any time. On the output side, out_valid,
// result, zero and illegal stay stable until the edge where out_ready is high.
module alu_slice_exec #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic             ctrl_legal;
    logic [WIDTH-1:0] a_shift, b_shift;
    logic [SLICE-1:0] a_k, b_k, b_eff, slice_res;
    logic [SLICE:0]   sum_ext;
    logic [WIDTH-1:0] result_next;

    function automatic logic is_legal(input logic [3:0] c);
        return (c == OP_AND) || (c == OP_OR) || (c == OP_ADD) || (c == OP_SUB);
    endfunction

    assign ctrl_legal = is_legal(ctrl);
    assign in_ready   = (state == IDLE) && !reset;
    assign state_dbg  = state;

    // Slice datapath: select slice cnt of the latched operands and combine it.
    always_comb begin
        a_shift     = a_q >> (cnt * SLICE);
        b_shift     = b_q >> (cnt * SLICE);
        a_k         = a_shift[SLICE-1:0];
        b_k         = b_shift[SLICE-1:0];
        b_eff       = (ctrl_q == OP_SUB) ? ~b_k : b_k;
        sum_ext     = {1'b0, a_k} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
        slice_res   = sum_ext[SLICE-1:0];
        if (ctrl_q == OP_AND) begin
            slice_res = a_k & b_k;
        end else if (ctrl_q == OP_OR) begin
            slice_res = a_k | b_k;
        end
        // Result register is cleared on accept, so OR-ing the slice in is a write.
        result_next = result | (WIDTH'(slice_res) << (cnt * SLICE));
    end

    // Next-state logic for the IDLE -> BUSY -> DONE sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ctrl_legal ? BUSY : DONE;
            BUSY:    if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latches, slice counter, carry and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            carry_q   <= 1'b0;
            ctrl_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_q  <= ctrl;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        result  <= '0;
                        cnt     <= '0;
                        carry_q <= (ctrl == OP_SUB);
                        if (ctrl_legal) begin
                            zero    <= 1'b0;
                            illegal <= 1'b0;
                        end else begin
                            // Illegal codes skip BUSY and report a zero result.
                            zero      <= 1'b1;
                            illegal   <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    result  <= result_next;
                    carry_q <= sum_ext[SLICE];
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        zero      <= (result_next == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
